// File: rtl/pc_next.sv
// pc_next: program-counter sequencer for the instruction-fetch stage.
//
// Presents a fetch address (pc) under a valid/ready handshake and chooses the
// next address from sequential pc+4, a jump target or a taken-branch target.
// A redirect that arrives while fetch is stalled is parked in a one-entry
// pending register and applied on the next accepted fetch.
//
// Build option: define PC_NEXT_DELAY_SLOT_EN to enable a single branch delay
// slot (DELAY state). Without it the DELAY state and its logic are absent.
//
// Handshake: fire = pc_valid & pc_ready. pc is offered whenever pc_valid is
// high; pc_valid never depends on pc_ready, and pc only changes on a fire.
//
// dbg_state / dbg_pending_vld expose the FSM state and the pending-target
// flag for observation; they carry no functional meaning for consumers.

module pc_next #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        pc_valid,
    input  logic        pc_ready,
    input  logic [31:0] br_pc4,
    input  logic [31:0] imm,
    input  logic [25:0] jTarget,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic        flush,
    output logic [1:0]  dbg_state,
    output logic        dbg_pending_vld
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01
`ifdef PC_NEXT_DELAY_SLOT_EN
        ,
        ST_DELAY = 2'b10
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    logic        fire;
    logic        redirect;
    logic [31:0] jump_tgt;
    logic [31:0] br_tgt;
    logic [31:0] redir_tgt;

    // Handshake, redirect decode and candidate targets (jump beats branch).
    always_comb begin
        pc_valid  = (state_q != ST_BOOT);
        fire      = pc_valid & pc_ready;
        redirect  = jump | (branch & zero);
        jump_tgt  = {br_pc4[31:28], jTarget, 2'b00};
        br_tgt    = br_pc4 + (imm << 2);
        redir_tgt = jump ? jump_tgt : br_tgt;
        pc4       = pc_q + 32'd4;
    end

    // Next-state logic: state transitions, next pc, flush and pending target.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        flush_d    = 1'b0;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;

        case (state_q)
            ST_BOOT: begin
                // Redirect inputs are ignored; fetch starts on the next edge.
                state_d = ST_RUN;
            end

            ST_RUN: begin
`ifdef PC_NEXT_DELAY_SLOT_EN
                // Capture the latest redirect; the accepting fetch steps into
                // the delay slot and the target is taken one fire later.
                if (redirect) begin
                    pend_tgt_d = redir_tgt;
                    pend_vld_d = 1'b1;
                end
                if (fire) begin
                    pc_d = pc4;
                    if (redirect || pend_vld_q) begin
                        state_d = ST_DELAY;
                    end
                end
`else
                if (redirect) begin
                    if (fire) begin
                        // A fresh redirect supersedes any older parked target.
                        pc_d       = redir_tgt;
                        flush_d    = 1'b1;
                        pend_vld_d = 1'b0;
                    end else begin
                        // Stalled: park it, latest redirect wins.
                        pend_tgt_d = redir_tgt;
                        pend_vld_d = 1'b1;
                    end
                end else if (fire) begin
                    if (pend_vld_q) begin
                        pc_d       = pend_tgt_q;
                        flush_d    = 1'b1;
                        pend_vld_d = 1'b0;
                    end else begin
                        pc_d = pc4;
                    end
                end
`endif
            end

`ifdef PC_NEXT_DELAY_SLOT_EN
            ST_DELAY: begin
                // Redirects are ignored while the delay slot is outstanding.
                if (fire) begin
                    pc_d       = pend_tgt_q;
                    flush_d    = 1'b1;
                    pend_vld_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
`endif

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    // Output mapping.
    always_comb begin
        pc              = pc_q;
        flush           = flush_q;
        dbg_state       = state_q;
        dbg_pending_vld = pend_vld_q;
    end

endmodule

// File: doc/pc_next.md
PC_NEXT -- requirements
Module: pc_next

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded by reset; it SHALL be word-aligned.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port pc  output  32  current fetch address to the instruction-fetch stage.
REQ-005 SHALL have port pc4  output  32  pc+4, combinational, modulo 2^32.
REQ-006 SHALL have port pc_valid  output  1  pc is a valid fetch request.
REQ-007 SHALL have port pc_ready  input  1  fetch stage accepts pc this cycle.
REQ-008 SHALL have port br_pc4  input  32  PC+4 of the resolving branch/jump instruction.
REQ-009 SHALL have port imm  input  32  sign-extended 16-bit branch offset from decode.
REQ-010 SHALL have port jTarget  input  26  jump field ins[25:0].
REQ-011 SHALL have ports branch, zero, jump, each input 1: branch-instruction flag, ALU zero flag, jump-instruction flag.
REQ-012 SHALL have port flush  output  1  one-cycle pulse when pc is loaded from a redirect target.

Function
REQ-013 Handshake: fire = pc_valid & pc_ready; pc SHALL change only on a fire cycle.
REQ-014 States: BOOT, RUN, plus DELAY when configured (REQ-026). After reset the state SHALL be BOOT. BOOT SHALL go to RUN on the first clock edge with rst low. RUN SHALL hold otherwise.
REQ-015 pc_valid SHALL be 0 in BOOT and 1 in RUN and DELAY.
REQ-016 redirect = jump | (branch & zero); redirect inputs SHALL be ignored in BOOT.
REQ-017 Jump target SHALL be {br_pc4[31:28], jTarget, 2'b00}.
REQ-018 Branch target SHALL be br_pc4 + (imm << 2), truncated to 32 bits.
REQ-019 When jump and branch&zero are both high, the jump target SHALL win.
REQ-020 On fire without a redirect or pending target, pc SHALL become pc+4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-021 On redirect & fire, pc SHALL become the target on the next edge, flush SHALL pulse for that one cycle, and no pending target SHALL be stored.
REQ-022 On redirect without fire, the target SHALL be stored in a one-entry pending register with pending_vld=1. On the next fire, pc SHALL load the pending target, flush SHALL pulse, and pending_vld SHALL clear.
REQ-023 A new redirect while pending_vld=1 SHALL overwrite the pending target (latest wins). A redirect coinciding with a fire SHALL take precedence over the older pending target.
REQ-024 flush SHALL be registered and SHALL be 0 in every cycle not covered by REQ-021/022/026.

Reset
REQ-025 While rst is high, the block SHALL immediately, without a clock, force pc=RESET_PC, pc_valid=0, flush=0, pending_vld=0, pending target=0, and state=BOOT. pc4 SHALL then equal RESET_PC+4. Reset asserted mid-redirect or mid-DELAY SHALL discard the pending target.

Configuration
REQ-026 Macro PC_NEXT_DELAY_SLOT_EN defined: a redirect accepted in RUN SHALL be captured, and the next fire SHALL advance pc to pc+4 (delay slot) and enter DELAY with flush=0. The following fire SHALL load the captured target, pulse flush, and return to RUN. Redirects arriving in DELAY SHALL be ignored.
REQ-027 Macro PC_NEXT_DELAY_SLOT_EN undefined: the DELAY state and its logic SHALL not exist, and redirects SHALL behave per REQ-021/022.

Verification
REQ-028 rst pulse, RESET_PC=32'h0000_0100, pc_ready=1 -> pc_valid=0 one cycle after release, then pc sequence 0x100, 0x104, 0x108.
REQ-029 pc=32'h0000_0040, branch=1, zero=1, br_pc4=32'h0000_0044, imm=32'hFFFF_FFFE, fire -> next pc=32'h0000_003C and flush=1 for one cycle.
REQ-030 jump=1 and branch=zero=1 together, br_pc4=32'hA000_0010, jTarget=26'h000_0100 -> next pc=32'hA000_0400.
REQ-031 Redirect to 0x200 with pc_ready=0, then a redirect to 0x300 with pc_ready=0, then pc_ready=1 -> pc holds during the stall, then pc=0x300 with flush=1; the 0x200 target is never fetched.
REQ-032 pc=32'hFFFF_FFFC, fire -> pc=32'h0000_0000; separately, with PC_NEXT_DELAY_SLOT_EN defined, a jump at pc=0x10 to 0x80 -> pc sequence 0x14 (flush=0) then 0x80 (flush=1).
